// File: rtl/frame_bank_scheduler_pkg.sv
// ============================================================================
// Module : fb_pkg
// Brief  : Shared types and constants for the triple-buffered frame scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  typedef logic [1:0] bank_idx_t;

  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned PIX_W        = 4;
  localparam int unsigned FRAME_PIXELS = 307200;

  // Power-on bank assignment: writer, display, ready slot
  localparam bank_idx_t W0 = 2'd0;
  localparam bank_idx_t R0 = 2'd2;
  localparam bank_idx_t S0 = 2'd1;

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bank_scheduler_rotator.sv
// ============================================================================
// Module : fb_bank_rotator
// Brief  : Holds the writer/display/ready bank permutation and rotates it on
//          frame commit and vsync swap events.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_bank_rotator
  import fb_pkg::*;
(
  input  logic      clk24,
  input  logic      rst_n,
  input  logic      commit,
  input  logic      swap,
  output bank_idx_t wr_bank,
  output bank_idx_t rd_bank,
  output logic      ready_valid,
  output logic      shown_valid
);

  bank_idx_t w_q, w_d;
  bank_idx_t r_q, r_d;
  bank_idx_t s_q, s_d;
  logic      rv_q, rv_d;
  logic      sv_q, sv_d;

  always_comb begin
    w_d  = w_q;
    r_d  = r_q;
    s_d  = s_q;
    rv_d = rv_q;
    sv_d = sv_q;
    if (commit && swap) begin
      // Freshly finished frame goes straight to display; ready slot untouched
      w_d  = r_q;
      r_d  = w_q;
      rv_d = 1'b0;
      sv_d = 1'b1;
    end else if (commit) begin
      s_d  = w_q;
      w_d  = s_q;
      rv_d = 1'b1;
    end else if (swap && rv_q) begin
      r_d  = s_q;
      s_d  = r_q;
      rv_d = 1'b0;
      sv_d = 1'b1;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      w_q  <= W0;
      r_q  <= R0;
      s_q  <= S0;
      rv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      w_q  <= w_d;
      r_q  <= r_d;
      s_q  <= s_d;
      rv_q <= rv_d;
      sv_q <= sv_d;
    end
  end

  assign wr_bank     = w_q;
  assign rd_bank     = r_q;
  assign ready_valid = rv_q;
  assign shown_valid = sv_q;

endmodule

`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
// ============================================================================
// Module : frame_bank_scheduler
// Brief  : Triple-buffer scheduler between camera capture and VGA scan-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_bank_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = fb_pkg::ADDR_W,
  parameter int unsigned PIX_W        = fb_pkg::PIX_W,
  parameter int unsigned FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic              clk24,
  input  logic              rst_n,
  input  logic              cam_frame_start,
  input  logic              cam_frame_done,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [PIX_W-1:0]  cam_data,
  input  logic              vga_vsync,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [PIX_W-1:0]  vga_pixel,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic [ADDR_W+1:0] mem_raddr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic [7:0]        frames_dropped,
  output logic [7:0]        frames_repeated
);

  localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(FRAME_PIXELS);

  wr_state_t         state_q, state_d;
  logic              vsync_prev_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W+1:0] mem_waddr_q, mem_waddr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]        dropped_q, dropped_d;
  logic [7:0]        repeated_q, repeated_d;
  logic              shown_dly_q, shown_dly_d;

  logic              swap, commit, wr_ok;
  logic              ready_valid, shown_valid;
  bank_idx_t         w_bank, r_bank;
  logic [ADDR_W-1:0] rd_addr;

  assign swap   = (vga_vsync == VSYNC_ACTIVE) && (vsync_prev_q != VSYNC_ACTIVE);
  assign commit = (state_q == W_ACTIVE) && cam_frame_done;
  assign wr_ok  = (state_q == W_ACTIVE) && cam_we && (cam_addr < PIX_LIMIT);

  fb_bank_rotator u_rotator (
    .clk24       (clk24),
    .rst_n       (rst_n),
    .commit      (commit),
    .swap        (swap),
    .wr_bank     (w_bank),
    .rd_bank     (r_bank),
    .ready_valid (ready_valid),
    .shown_valid (shown_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:   if (cam_frame_start) state_d = W_ACTIVE;
      W_ACTIVE: if (cam_frame_done)  state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  // Bank is sampled before the commit takes effect, so commit-cycle pixels land in the old bank
  always_comb begin
    mem_we_d    = wr_ok;
    mem_waddr_d = wr_ok ? {w_bank, cam_addr} : mem_waddr_q;
    mem_wdata_d = wr_ok ? cam_data : mem_wdata_q;
    dropped_d   = (commit && ready_valid) ? sat_inc(dropped_q) : dropped_q;
    repeated_d  = (swap && !commit && !ready_valid) ? sat_inc(repeated_q) : repeated_q;
    shown_dly_d = shown_valid;
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= W_IDLE;
      vsync_prev_q <= ~VSYNC_ACTIVE;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      dropped_q    <= '0;
      repeated_q   <= '0;
      shown_dly_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vga_vsync;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      dropped_q    <= dropped_d;
      repeated_q   <= repeated_d;
      shown_dly_q  <= shown_dly_d;
    end
  end

  assign rd_addr         = (vga_addr < PIX_LIMIT) ? vga_addr : '0;
  assign mem_raddr       = {r_bank, rd_addr};
  assign vga_pixel       = shown_dly_q ? mem_rdata : '0;
  assign mem_we          = mem_we_q;
  assign mem_waddr       = mem_waddr_q;
  assign mem_wdata       = mem_wdata_q;
  assign wr_bank         = w_bank;
  assign rd_bank         = r_bank;
  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_bank_scheduler.sv
// ============================================================================
// Module : tb_frame_bank_scheduler
// Brief  : Self-checking bench for frame_bank_scheduler with a BRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_bank_scheduler;

  logic        clk24 = 1'b0;
  logic        rst_n;
  logic        cam_frame_start, cam_frame_done, cam_we;
  logic [18:0] cam_addr;
  logic [3:0]  cam_data;
  logic        vga_vsync;
  logic [18:0] vga_addr;
  logic [3:0]  vga_pixel;
  logic        mem_we;
  logic [20:0] mem_waddr;
  logic [3:0]  mem_wdata;
  logic [20:0] mem_raddr;
  logic [3:0]  mem_rdata = 4'h0;
  logic [1:0]  wr_bank, rd_bank;
  logic [7:0]  frames_dropped, frames_repeated;

  frame_bank_scheduler dut (
    .clk24           (clk24),
    .rst_n           (rst_n),
    .cam_frame_start (cam_frame_start),
    .cam_frame_done  (cam_frame_done),
    .cam_we          (cam_we),
    .cam_addr        (cam_addr),
    .cam_data        (cam_data),
    .vga_vsync       (vga_vsync),
    .vga_addr        (vga_addr),
    .vga_pixel       (vga_pixel),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .mem_raddr       (mem_raddr),
    .mem_rdata       (mem_rdata),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated)
  );

  always #5 clk24 = ~clk24;

  int unsigned cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  // Frame BRAM model with one cycle of read latency
  logic [3:0] bram [0:2097151];
  always @(posedge clk24) begin
    if (mem_we) bram[mem_waddr] <= mem_wdata;
    mem_rdata <= bram[mem_raddr];
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [20:0] waddr;
    logic [3:0]  wdata;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk24) begin
    sb_t e;
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_spurious: mem_we at waddr 0x%0h, expected no write", mem_waddr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_waddr), 32'(e.waddr));
        chk("wr_data", 32'(mem_wdata), 32'(e.wdata));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [3:0]  data;
    logic        exp_we;
  } pix_vec_t;

  typedef struct {
    logic [18:0] va;
    logic [18:0] exp_lo;
  } rd_vec_t;

  pix_vec_t pix_tab[13];
  rd_vec_t  rd_tab[6];

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  // Drive one camera pixel; expected BRAM write is queued when it is legal
  task automatic drive_pix(input pix_vec_t v, input logic [1:0] bank);
    sb_t e;
    cam_we   = v.we;
    cam_addr = v.addr;
    cam_data = v.data;
    if (v.exp_we) begin
      e.cyc   = cyc + 1;
      e.waddr = {bank, v.addr};
      e.wdata = v.data;
      sb.push_back(e);
    end
    tick();
    cam_we = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] bank, input logic [3:0] data);
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    drive_pix('{1'b1, 19'd0, data, 1'b1}, bank);
    cam_frame_done = 1'b1;
    tick();
    cam_frame_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 10; i++) pix_tab[i] = '{1'b1, 19'(i), 4'hA, 1'b1};
    pix_tab[10] = '{1'b1, 19'd307200, 4'hF, 1'b0};
    pix_tab[11] = '{1'b0, 19'd20,     4'hF, 1'b0};
    pix_tab[12] = '{1'b1, 19'd307199, 4'h3, 1'b1};
    rd_tab[0] = '{19'd0,      19'd0};
    rd_tab[1] = '{19'd5,      19'd5};
    rd_tab[2] = '{19'd307199, 19'd307199};
    rd_tab[3] = '{19'd307200, 19'd0};
    rd_tab[4] = '{19'd400000, 19'd0};
    rd_tab[5] = '{19'd524287, 19'd0};

    rst_n = 1'b0;
    cam_frame_start = 1'b0; cam_frame_done = 1'b0; cam_we = 1'b0;
    cam_addr = '0; cam_data = '0; vga_vsync = 1'b1; vga_addr = '0;
    repeat (3) tick();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 2);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_dropped", frames_dropped, 0);
    chk("rst_repeated", frames_repeated, 0);
    chk("rst_pixel", vga_pixel, 0);
    rst_n = 1'b1;
    tick();

    // Vsync with nothing ready: display repeats, counted once per edge
    vga_vsync = 1'b0;
    tick();
    chk("nofr_rd_bank", rd_bank, 2);
    chk("nofr_repeated", frames_repeated, 1);
    tick(); tick();
    chk("vsync_level_no_recount", frames_repeated, 1);
    chk("nofr_pixel", vga_pixel, 0);
    vga_vsync = 1'b1;
    tick();

    // First frame into bank 0, one extra pixel in the commit cycle
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    foreach (pix_tab[i]) drive_pix(pix_tab[i], 2'd0);
    cam_frame_done = 1'b1;
    drive_pix('{1'b1, 19'd11, 4'h5, 1'b1}, 2'd0);
    cam_frame_done = 1'b0;
    chk("commit1_wr_bank", wr_bank, 1);
    chk("commit1_rd_bank", rd_bank, 2);
    chk("commit1_dropped", frames_dropped, 0);

    vga_addr  = 19'd5;
    vga_vsync = 1'b0;
    tick();
    chk("swap1_rd_bank", rd_bank, 0);
    chk("swap1_raddr", mem_raddr, {2'd0, 19'd5});
    chk("swap1_repeated", frames_repeated, 1);
    vga_vsync = 1'b1;
    tick();
    chk("swap1_pixel_a5", vga_pixel, 4'hA);
    vga_addr = 19'd307199;
    tick();
    chk("pixel_last_addr", vga_pixel, 4'h3);
    vga_addr = 19'd11;
    tick();
    chk("pixel_commit_cycle", vga_pixel, 4'h5);

    // Two commits without a vsync: the older ready frame is dropped
    send_frame(2'd1, 4'h6);
    chk("commitA_wr_bank", wr_bank, 2);
    chk("commitA_dropped", frames_dropped, 0);
    send_frame(2'd2, 4'h7);
    chk("commitB_wr_bank", wr_bank, 1);
    chk("commitB_dropped", frames_dropped, 1);
    vga_addr  = 19'd0;
    vga_vsync = 1'b0;
    tick();
    chk("swap2_rd_bank", rd_bank, 2);
    vga_vsync = 1'b1;
    tick();
    chk("swap2_pixel_fresh", vga_pixel, 4'h7);
    chk("swap2_repeated", frames_repeated, 1);

    foreach (rd_tab[i]) begin
      vga_addr = rd_tab[i].va;
      #1;
      chk($sformatf("raddr_mux[%0d]", i), mem_raddr, {2'd2, rd_tab[i].exp_lo});
    end

    // Restart while active commits only once
    cam_frame_start = 1'b1;
    tick(); tick();
    cam_frame_start = 1'b0;
    cam_frame_done  = 1'b1;
    tick();
    cam_frame_done  = 1'b0;
    chk("restart_wr_bank", wr_bank, 0);
    chk("restart_dropped", frames_dropped, 1);

    cam_frame_done = 1'b1;
    tick();
    cam_frame_done = 1'b0;
    chk("idle_done_wr_bank", wr_bank, 0);
    chk("idle_done_rd_bank", rd_bank, 2);

    // Reset in the middle of a frame with a ready frame pending
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    drive_pix('{1'b1, 19'd3, 4'h9, 1'b1}, 2'd0);
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_wr_bank", wr_bank, 0);
    chk("mrst_rd_bank", rd_bank, 2);
    chk("mrst_mem_we", mem_we, 0);
    chk("mrst_mem_waddr", mem_waddr, 0);
    chk("mrst_mem_wdata", mem_wdata, 0);
    chk("mrst_dropped", frames_dropped, 0);
    chk("mrst_repeated", frames_repeated, 0);
    chk("mrst_pixel", vga_pixel, 0);
    cam_frame_done = 1'b1;
    tick();
    cam_frame_done = 1'b0;
    chk("mrst_done_ignored", wr_bank, 0);

    // Commit and vsync in the same cycle from the reset assignment
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    cam_frame_done  = 1'b1;
    vga_vsync       = 1'b0;
    tick();
    cam_frame_done  = 1'b0;
    chk("both_rd_bank", rd_bank, 0);
    chk("both_wr_bank", wr_bank, 2);
    chk("both_dropped", frames_dropped, 0);
    chk("both_repeated", frames_repeated, 0);
    vga_vsync = 1'b1;
    tick();
    vga_vsync = 1'b0;
    tick();
    chk("both_nothing_ready_rd", rd_bank, 0);
    chk("both_nothing_ready_rep", frames_repeated, 1);
    vga_vsync = 1'b1;
    tick();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    cam_frame_done  = 1'b1;
    tick();
    cam_frame_done  = 1'b0;
    chk("both_ready_slot_kept", wr_bank, 1);
    chk("both_after_dropped", frames_dropped, 0);

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
